// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared FSM state encoding and operation codes for the bit-serial adder
package serial_alu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller driving one shared full-adder cell, LSB first
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, op_sub       : request (sampled in IDLE), 0 = a+b+cin, 1 = a-b
//   a, b, cin           : operands and add carry-in, captured on accepted start
//   busy, done          : busy during the WIDTH bit steps, done one-cycle pulse when result valid
//   sum, cout, ovf      : result, final carry (1 = no borrow on subtract), signed overflow
module serial_add_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_sa, r_sb, r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_c, w_s, w_co, w_last;
  fa_cell u_fa (.a(r_sa[0]), .b(r_sb[0]), .ci(r_c), .s(w_s), .co(w_co));
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign busy   = r_state == RUN;
  assign done   = r_state == FIN;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? FIN : RUN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // Results are loaded on the last bit step, so they are valid the cycle done is high.
  // ovf compares the carry into the MSB (r_c before update) with the carry out of it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_c   <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_sa  <= a;
      r_sb  <= op_sub == OP_SUB ? ~b : b;
      r_c   <= op_sub == OP_ADD ? cin : 1'b1;
      r_cnt <= '0;
      r_res <= '0;
    end else if (r_state == RUN) begin
      r_res <= {w_s, r_res[WIDTH-1:1]};
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_c   <= w_co;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        sum  <= {w_s, r_res[WIDTH-1:1]};
        cout <= w_co;
        ovf  <= r_c ^ w_co;
      end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_sub = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         busy, done, cout, ovf;
  logic [W+1:0] sb[$];
  int           total = 0, bad = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic         ci, v;
    yy   = s ? ~y : y;
    ci   = s ? 1'b1 : c;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci};
    v    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {full[W-1:0], full[W], v};
  endfunction

  always @(negedge clk)
    if (rst_n && done) begin
      if (sb.size() == 0) chk("unexp_done", 32'(done), 32'd0);
      else chk("result", 32'({sum, cout, ovf}), 32'(sb.pop_front()));
    end

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    @(negedge clk);
    start = 1'b1; a = x; b = y; cin = c; op_sub = s;
    sb.push_back(model(x, y, c, s));
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("busy_run", 32'({busy, done}), 32'b10);
    end
    @(negedge clk);
    chk("done_fin", 32'({busy, done}), 32'b01);
    @(negedge clk);
    chk("done_pulse_end", 32'({busy, done}), 32'b00);
  endtask

  initial begin
    #12;
    chk("reset_out", 32'({busy, done, sum, cout, ovf}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    do_op(8'h5A, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold", 32'({done, sum, cout, ovf}), 32'({1'b0, 8'h8D, 1'b0, 1'b1}));
    end
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0);
    do_op(8'h10, 8'h20, 1'b1, 1'b1);
    do_op(8'h80, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    // start held high with operands changing every cycle
    for (int j = 0; j < 3 * (W + 2); j++) begin
      @(negedge clk);
      chk("cont_busy", 32'(busy), 32'(j % (W + 2) >= 1 && j % (W + 2) <= W));
      chk("cont_done", 32'(done), 32'(j % (W + 2) == W + 1));
      start = 1'b1; a = $urandom; b = $urandom; cin = $urandom; op_sub = $urandom;
      if (j % (W + 2) == 0) sb.push_back(model(a, b, cin, op_sub));
    end
    @(negedge clk);
    start = 1'b0;
    chk("cont_last_done", 32'({busy, done}), 32'b00);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    // reset in the third RUN cycle
    do_op(8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h33; cin = 1'b0; op_sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'({busy, done, sum, cout, ovf}), 32'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'({busy, done}), 32'd0);
    end
    do_op(8'h5A, 8'h33, 1'b0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end
endmodule
